// File: rtl/switch_word_scheduler.sv
// -----------------------------------------------------------------------------
// switch_word_scheduler
//
// Sequences switch-word updates into a datapath. A host word is buffered in a
// one-entry pending register, then launched from IDLE: W is loaded, dp_reset is
// pulsed for RST_CYCLES cycles, the block waits (up to TIMEOUT cycles) for the
// decoder to report completion, and finally holds the decoded word for DWELL
// cycles before returning to IDLE. Leaving reset runs the same sequence for W=0.
//
// Ports
//   clk          in   core clock, rising edge
//   reset        in   asynchronous active-low reset
//   W_in[12:0]   in   host switch word
//   W_valid      in   host word present
//   W_ready      out  pending register empty, word can be accepted
//   decoderDone  in   datapath decoder finished for the current W
//   clear_err    in   clears the sticky timeout flag
//   W[12:0]      out  word driven to the datapath
//   dp_reset     out  active-high datapath reset
//   en           out  datapath enable (low while a timeout is flagged)
//   busy         out  high whenever the sequencer is not IDLE
//   err_range    out  one-cycle pulse when an out-of-range word is dropped
//   err_timeout  out  sticky decoder timeout flag
//   update_count out  completed decodes, wraps modulo 256
// -----------------------------------------------------------------------------
module switch_word_scheduler #(
    parameter int RST_CYCLES = 3,
    parameter int TIMEOUT    = 1024,
    parameter int DWELL      = 2048,
    parameter int W_MAX      = 6479
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] W_in,
    input  logic        W_valid,
    output logic        W_ready,
    input  logic        decoderDone,
    input  logic        clear_err,
    output logic [12:0] W,
    output logic        dp_reset,
    output logic        en,
    output logic        busy,
    output logic        err_range,
    output logic        err_timeout,
    output logic [7:0]  update_count
);

    // One counter serves all three timed states, so size it for the longest.
    localparam int CNT_M1  = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
    localparam int CNT_MAX = (CNT_M1 > DWELL) ? CNT_M1 : DWELL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL - 1);
    localparam logic [12:0]      W_LIM        = 13'(W_MAX);

    typedef enum logic [1:0] {
        PULSE     = 2'd0,
        WAIT_DONE = 2'd1,
        HOLD      = 2'd2,
        IDLE      = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [12:0]      w_q;
    logic [12:0]      pend_w_q;
    logic             pend_valid_q;
    logic             w_ready_q;
    logic             dp_reset_q;
    logic             busy_q;
    logic             err_range_q;
    logic             err_timeout_q;
    logic [7:0]       update_count_q;

    logic accept_d;
    logic in_range_d;
    logic launch_d;

    // Acceptance needs the pending slot empty, launch needs it full, so the two
    // can never fire on the same edge.
    always_comb begin
        accept_d   = W_valid && w_ready_q;
        in_range_d = (W_in <= W_LIM);
        launch_d   = (state_q == IDLE) && pend_valid_q;
    end

    // Pending word payload; only meaningful while pend_valid_q is set.
    always_ff @(posedge clk) begin
        if (accept_d && in_range_d) begin
            pend_w_q <= W_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= PULSE;
            cnt_q          <= '0;
            w_q            <= '0;
            pend_valid_q   <= 1'b0;
            w_ready_q      <= 1'b1;
            dp_reset_q     <= 1'b1;
            busy_q         <= 1'b1;
            err_range_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
            update_count_q <= '0;
        end else begin
            err_range_q <= accept_d && !in_range_d;

            if (launch_d) begin
                pend_valid_q <= 1'b0;
                w_ready_q    <= 1'b1;
            end else if (accept_d && in_range_d) begin
                pend_valid_q <= 1'b1;
                w_ready_q    <= 1'b0;
            end

            // A timeout detected below overrides this clear on the same edge.
            if (clear_err) begin
                err_timeout_q <= 1'b0;
            end

            case (state_q)
                PULSE: begin
                    if (cnt_q == RST_LAST) begin
                        dp_reset_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (decoderDone) begin
                        update_count_q <= update_count_q + 8'd1;
                        cnt_q          <= '0;
                        state_q        <= HOLD;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_timeout_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == DWELL_LAST) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (pend_valid_q) begin
                        w_q        <= pend_w_q;
                        dp_reset_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= PULSE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign W            = w_q;
    assign W_ready      = w_ready_q;
    assign dp_reset     = dp_reset_q;
    assign busy         = busy_q;
    assign err_range    = err_range_q;
    assign err_timeout  = err_timeout_q;
    assign update_count = update_count_q;
    assign en           = !err_timeout_q;

endmodule
